// File: rtl/ghost_catch_ctrl.sv
// Ghost/Pacman catch detector with lives bookkeeping and mover control.
// Drives freeze, respawn and game-over back to the sprite movers.
module ghost_catch_ctrl #(
    parameter int HIT_DIST     = 12,
    parameter int CONFIRM      = 2,
    parameter int LIVES        = 3,
    parameter int FREEZE_TICKS = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       move_tick,
    input  logic       start,
    input  logic [9:0] pac_x,
    input  logic [8:0] pac_y,
    input  logic [9:0] ghost_x,
    input  logic [8:0] ghost_y,
    output logic       freeze,
    output logic       respawn,
    output logic       hit,
    output logic [1:0] lives,
    output logic       game_over,
    output logic [1:0] state
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PLAY   = 2'd1;
    localparam logic [1:0] S_FREEZE = 2'd2;
    localparam logic [1:0] S_OVER   = 2'd3;

    localparam logic [9:0] HIT_LIM   = 10'(HIT_DIST);
    localparam logic [3:0] CONF_LAST = 4'(CONFIRM - 1);
    localparam logic [1:0] LIVES_INI = 2'(LIVES);
    localparam logic [7:0] FRZ_INI   = 8'(FREEZE_TICKS);

    logic [1:0] state_q;
    logic [1:0] lives_q;
    logic [3:0] conf_cnt;
    logic [7:0] frz_cnt;
    logic       hit_q;
    logic       resp_q;

    logic [9:0] dx;
    logic [9:0] dy;
    logic       overlap;

    // Larger minus smaller, so far-apart coordinates never wrap into a hit.
    always_comb begin
        dx = (pac_x >= ghost_x) ? (pac_x - ghost_x) : (ghost_x - pac_x);
        dy = {1'b0, (pac_y >= ghost_y) ? (pac_y - ghost_y)
                                       : (ghost_y - pac_y)};
        overlap = (dx < HIT_LIM) && (dy < HIT_LIM);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            lives_q  <= LIVES_INI;
            conf_cnt <= 4'd0;
            frz_cnt  <= 8'd0;
            hit_q    <= 1'b0;
            resp_q   <= 1'b0;
        end else begin
            hit_q  <= 1'b0;
            resp_q <= 1'b0;
            case (state_q)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        state_q  <= S_PLAY;
                        lives_q  <= LIVES_INI;
                        conf_cnt <= 4'd0;
                        resp_q   <= 1'b1;
                    end
                end
                S_PLAY: begin
                    if (move_tick) begin
                        if (!overlap) begin
                            conf_cnt <= 4'd0;
                        end else if (conf_cnt != CONF_LAST) begin
                            conf_cnt <= conf_cnt + 4'd1;
                        end else begin
                            hit_q    <= 1'b1;
                            conf_cnt <= 4'd0;
                            if (lives_q != 2'd0)
                                lives_q <= lives_q - 2'd1;
                            if (lives_q <= 2'd1) begin
                                state_q <= S_OVER;
                            end else begin
                                state_q <= S_FREEZE;
                                frz_cnt <= FRZ_INI;
                            end
                        end
                    end
                end
                default: begin
                    if (move_tick) begin
                        if (frz_cnt <= 8'd1) begin
                            state_q  <= S_PLAY;
                            resp_q   <= 1'b1;
                            conf_cnt <= 4'd0;
                            frz_cnt  <= 8'd0;
                        end else begin
                            frz_cnt <= frz_cnt - 8'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign state     = state_q;
    assign hit       = hit_q;
    assign respawn   = resp_q;
    assign freeze    = (state_q != S_PLAY);
    assign game_over = (state_q == S_OVER);
    assign lives     = (state_q == S_OVER) ? 2'd0 : lives_q;

endmodule

// File: doc/ghost_catch_ctrl.md
Name: ghost_catch_ctrl

Overview:
- Downstream consumer of the ghost mover's position outputs (x, y).
- Compares ghost position against Pacman position every movement tick and confirms a catch after consecutive overlapping samples.
- Manages the lives counter and drives the game-level freeze, respawn and game-over controls back to the Pacman and ghost movers.
- Sits between the sprite movers and the display/score logic.

Parameters:
- HIT_DIST, 12: overlap threshold in pixels; overlap when |dx| < HIT_DIST and |dy| < HIT_DIST.
- CONFIRM, 2: consecutive overlapping tick samples required to declare a catch (1..15).
- LIVES, 3: lives loaded at game start (1..3).
- FREEZE_TICKS, 64: ticks spent frozen after a non-fatal catch (1..255).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- move_tick  in  1  single-cycle enable, same rate as the sprite movement clock
- start  in  1  level, start/restart request
- pac_x  in  10  Pacman X
- pac_y  in  9  Pacman Y
- ghost_x  in  10  ghost X
- ghost_y  in  9  ghost Y
- freeze  out  1  high = movers must hold position
- respawn  out  1  one-cycle pulse: movers reload start positions
- hit  out  1  one-cycle pulse on confirmed catch
- lives  out  2  remaining lives
- game_over  out  1  high in OVER state
- state  out  2  0 = IDLE, 1 = PLAY, 2 = FREEZE, 3 = OVER

Behaviour:
- **Clock and reset.** Single clock (clk); reset is synchronous and active-low (rst). All state changes occur on rising clk edges.
- **Reset values** (rst low at an edge): state=IDLE, lives=LIVES, freeze=1, respawn=0, hit=0, game_over=0, confirm count=0, freeze count=0.
  - Reset applies from any state, including mid-FREEZE or mid-confirm.
- **Overlap (combinational).**
  - dx = |pac_x - ghost_x| in 10 bits, unsigned, larger minus smaller.
  - dy = same on 9-bit Y, zero-extended to 10 bits.
  - overlap = (dx < HIT_DIST) && (dy < HIT_DIST).
  - No wrap-around: a difference of 1023 is treated as far apart.
- **Sampling.** Overlap is acted on only at edges where move_tick=1. move_tick is ignored outside PLAY and FREEZE.
- **IDLE.**
  - Outputs: freeze=1, game_over=0.
  - start=1 → PLAY; lives<=LIVES; respawn pulses for 1 cycle; confirm count cleared.
- **PLAY.**
  - Outputs: freeze=0.
  - On a tick with overlap=0: confirm count<=0.
  - On a tick with overlap=1 and count<CONFIRM-1: count++.
  - On a tick with overlap=1 and count==CONFIRM-1: hit pulses 1 cycle; lives<=lives-1; count<=0.
    - If lives was 1 → OVER.
    - Otherwise → FREEZE, with freeze count<=FREEZE_TICKS.
  - start is ignored in PLAY.
- **FREEZE.**
  - Outputs: freeze=1.
  - Each tick decrements the freeze count.
  - On the tick where count==1: → PLAY, respawn pulses 1 cycle, confirm count<=0.
  - Overlap and start are ignored.
- **OVER.**
  - Outputs: freeze=1, game_over=1, lives=0.
  - start=1 → PLAY, lives<=LIVES, respawn pulses. (Restart path is direct; IDLE is not revisited.)
- **Latency.** hit, respawn and state changes are registered and visible in the cycle after the deciding edge. freeze and game_over are decoded from the registered state.
- **Pulse width.** hit and respawn are exactly 1 cycle wide and never asserted simultaneously.
- **lives limits.** lives never underflows and never exceeds LIVES.
- **Same-edge start and tick in IDLE/OVER.** The start transition wins; the tick is discarded.

Test Plan:
- **Reset/start.** Hold rst=0 3 cycles → state=0, lives=3, freeze=1. Then start=1 → next cycle state=1, respawn=1 for 1 cycle, freeze=0.
- **Confirmed catch.** PLAY, pac=(200,146), ghost=(205,150), 2 ticks → hit pulse after 2nd tick, lives=2, state=2, freeze=1. After 64 further ticks → respawn pulse, state=1.
- **Glitch reject.** Overlap on 1 tick, pac moved to (100,146) on the next tick, then overlap again for 1 tick → no hit, lives stays 3.
- **Boundary.** dx=11,dy=0 for 2 ticks → hit. Repeat with dx=12 → no hit. Repeat with pac_x=0, ghost_x=1023 → no hit.
- **Game over.** Three confirmed catches → third hit gives state=3, game_over=1, lives=0. Further overlap ticks → no hit. start=1 → state=1, lives=3, respawn pulse.
- **Reset mid-FREEZE.** rst=0 after 10 of 64 freeze ticks → state=0, lives=3, no respawn pulse, freeze=1.
